// File: rtl/ball_motion_pkg.sv
// Shared definitions for the ball kinematics slice: table bounds, direction
// constants, motion state encoding and saturating helpers.
package dang9_pkg;

    localparam logic [9:0] DEF_X_MIN  = 10'd32;
    localparam logic [9:0] DEF_X_MAX  = 10'd607;
    localparam logic [9:0] DEF_Y_MIN  = 10'd32;
    localparam logic [9:0] DEF_Y_MAX  = 10'd447;
    localparam logic [9:0] DEF_INIT_X = 10'd160;
    localparam logic [9:0] DEF_INIT_Y = 10'd240;
    localparam logic [9:0] DEF_V_MAX  = 10'd15;
    localparam int unsigned DEF_FRICTION_DIV = 8;
    localparam int unsigned DEF_HOLD_FRAMES  = 4;
    localparam int unsigned BALL_D           = 24;

    localparam logic signed [9:0] DIR_POS = 10'sd1;
    localparam logic signed [9:0] DIR_NEG = -10'sd1;

    typedef enum logic [1:0] {
        IDLE,
        MOVING,
        HOLD
    } state_t;

    // |v| saturated to vmax; the 11-bit magnitude keeps -512 representable.
    function automatic logic [9:0] sat_abs(input logic signed [9:0] v,
                                           input logic [9:0] vmax);
        logic [10:0] mag;
        mag = v[9] ? (11'd0 - {1'b1, v}) : {1'b0, v};
        return (mag > {1'b0, vmax}) ? vmax : mag[9:0];
    endfunction

    function automatic logic [9:0] clamp_u(input logic [9:0] v,
                                           input logic [9:0] lo,
                                           input logic [9:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic signed [9:0] dir_of(input logic signed [9:0] d);
        return d[9] ? DIR_NEG : DIR_POS;
    endfunction

endpackage

// File: rtl/ball_motion_if.sv
// Command/status bundle between a ball_motion instance and its environment.
interface ball_motion_if;
    logic              frame_tick;
    logic              place_valid;
    logic [9:0]        place_x;
    logic [9:0]        place_y;
    logic              shot_valid;
    logic [9:0]        shot_vx;
    logic [9:0]        shot_vy;
    logic signed [9:0] shot_dx;
    logic signed [9:0] shot_dy;
    logic              coll_valid;
    logic signed [9:0] coll_vx;
    logic signed [9:0] coll_vy;
    logic signed [9:0] coll_dx;
    logic signed [9:0] coll_dy;
    logic [9:0]        x;
    logic [9:0]        y;
    logic [9:0]        vx;
    logic [9:0]        vy;
    logic signed [9:0] dx;
    logic signed [9:0] dy;
    logic              moving;
    logic              wall_hit;

    modport master (
        output frame_tick, place_valid, place_x, place_y,
               shot_valid, shot_vx, shot_vy, shot_dx, shot_dy,
               coll_valid, coll_vx, coll_vy, coll_dx, coll_dy,
        input  x, y, vx, vy, dx, dy, moving, wall_hit
    );

    modport slave (
        input  frame_tick, place_valid, place_x, place_y,
               shot_valid, shot_vx, shot_vy, shot_dx, shot_dy,
               coll_valid, coll_vx, coll_vy, coll_dx, coll_dy,
        output x, y, vx, vy, dx, dy, moving, wall_hit
    );
endinterface

// File: rtl/ball_motion_axis_step.sv
// One-axis position advance with cushion reflection (combinational).
module axis_step (
    input  logic [9:0]        i_pos,
    input  logic [9:0]        i_v,
    input  logic signed [9:0] i_d,
    input  logic [9:0]        i_min,
    input  logic [9:0]        i_max,
    output logic [9:0]        o_pos_next,
    output logic signed [9:0] o_d_next,
    output logic              o_hit
);
    logic signed [11:0] w_delta;
    logic signed [11:0] w_n;

    always_comb begin
        w_delta    = i_d[9] ? -$signed({2'b00, i_v}) : $signed({2'b00, i_v});
        w_n        = $signed({2'b00, i_pos}) + w_delta;
        o_pos_next = w_n[9:0];
        o_d_next   = i_d;
        o_hit      = 1'b0;
        if (w_n >= $signed({2'b00, i_max})) begin
            o_pos_next = i_max;
            o_d_next   = -10'sd1;
            o_hit      = 1'b1;
        end else if (w_n <= $signed({2'b00, i_min})) begin
            o_pos_next = i_min;
            o_d_next   = 10'sd1;
            o_hit      = 1'b1;
        end
    end
endmodule

// File: rtl/ball_motion.sv
// Per-ball kinematics register stage: frame stepping, cushion reflection,
// friction decay, collision/shot/respot loading.
module ball_motion
    import dang9_pkg::*;
#(
    parameter logic [9:0]  X_MIN        = DEF_X_MIN,
    parameter logic [9:0]  X_MAX        = DEF_X_MAX,
    parameter logic [9:0]  Y_MIN        = DEF_Y_MIN,
    parameter logic [9:0]  Y_MAX        = DEF_Y_MAX,
    parameter logic [9:0]  INIT_X       = DEF_INIT_X,
    parameter logic [9:0]  INIT_Y       = DEF_INIT_Y,
    parameter logic [9:0]  V_MAX        = DEF_V_MAX,
    parameter int unsigned FRICTION_DIV = DEF_FRICTION_DIV,
    parameter int unsigned HOLD_FRAMES  = DEF_HOLD_FRAMES
) (
    input  logic         clk,
    input  logic         rst,
    ball_motion_if.slave bus
);
    state_t            r_state, w_state_n;
    logic [9:0]        r_x, r_y, r_vx, r_vy;
    logic signed [9:0] r_dx, r_dy;
    logic [7:0]        r_fric_cnt, r_hold_cnt;
    logic              r_moving, r_wall_hit;

    logic [9:0]        w_x_n, w_y_n, w_vx_n, w_vy_n;
    logic signed [9:0] w_dx_n, w_dy_n;
    logic [7:0]        w_fric_n, w_hold_n;
    logic              w_wall_hit_n;

    logic [9:0]        w_x_step, w_y_step;
    logic signed [9:0] w_dx_step, w_dy_step;
    logic              w_hit_x, w_hit_y;

    axis_step u_step_x (
        .i_pos(r_x), .i_v(r_vx), .i_d(r_dx), .i_min(X_MIN), .i_max(X_MAX),
        .o_pos_next(w_x_step), .o_d_next(w_dx_step), .o_hit(w_hit_x)
    );

    axis_step u_step_y (
        .i_pos(r_y), .i_v(r_vy), .i_d(r_dy), .i_min(Y_MIN), .i_max(Y_MAX),
        .o_pos_next(w_y_step), .o_d_next(w_dy_step), .o_hit(w_hit_y)
    );

    always_comb begin
        w_state_n    = r_state;
        w_x_n        = r_x;
        w_y_n        = r_y;
        w_vx_n       = r_vx;
        w_vy_n       = r_vy;
        w_dx_n       = r_dx;
        w_dy_n       = r_dy;
        w_fric_n     = r_fric_cnt;
        w_hold_n     = r_hold_cnt;
        w_wall_hit_n = 1'b0;

        // An accepted collision pre-empts everything else, including the frame step.
        if (bus.coll_valid && r_state != HOLD) begin
            w_vx_n    = sat_abs(bus.coll_vx, V_MAX);
            w_vy_n    = sat_abs(bus.coll_vy, V_MAX);
            w_dx_n    = dir_of(bus.coll_dx);
            w_dy_n    = dir_of(bus.coll_dy);
            w_hold_n  = 8'(HOLD_FRAMES);
            w_fric_n  = '0;
            w_state_n = (w_vx_n == '0 && w_vy_n == '0) ? IDLE : HOLD;
        end else if (r_state == IDLE) begin
            if (bus.place_valid) begin
                w_x_n = clamp_u(bus.place_x, X_MIN, X_MAX);
                w_y_n = clamp_u(bus.place_y, Y_MIN, Y_MAX);
            end else if (bus.shot_valid) begin
                w_vx_n   = (bus.shot_vx > V_MAX) ? V_MAX : bus.shot_vx;
                w_vy_n   = (bus.shot_vy > V_MAX) ? V_MAX : bus.shot_vy;
                w_dx_n   = dir_of(bus.shot_dx);
                w_dy_n   = dir_of(bus.shot_dy);
                w_fric_n = '0;
                if (w_vx_n != '0 || w_vy_n != '0)
                    w_state_n = MOVING;
            end
        end else if (bus.frame_tick) begin
            w_x_n        = w_x_step;
            w_y_n        = w_y_step;
            w_dx_n       = w_dx_step;
            w_dy_n       = w_dy_step;
            w_wall_hit_n = w_hit_x | w_hit_y;

            if (r_fric_cnt == 8'(FRICTION_DIV - 1)) begin
                w_fric_n = '0;
                if (r_vx != '0) w_vx_n = r_vx - 10'd1;
                if (r_vy != '0) w_vy_n = r_vy - 10'd1;
            end else begin
                w_fric_n = r_fric_cnt + 8'd1;
            end

            if (r_state == HOLD) begin
                if (r_hold_cnt <= 8'd1) begin
                    w_hold_n  = '0;
                    w_state_n = MOVING;
                end else begin
                    w_hold_n = r_hold_cnt - 8'd1;
                end
            end

            if (w_vx_n == '0 && w_vy_n == '0) begin
                w_state_n = IDLE;
                w_fric_n  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_x        <= INIT_X;
            r_y        <= INIT_Y;
            r_vx       <= '0;
            r_vy       <= '0;
            r_dx       <= DIR_POS;
            r_dy       <= DIR_POS;
            r_fric_cnt <= '0;
            r_hold_cnt <= '0;
            r_moving   <= 1'b0;
            r_wall_hit <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_x        <= w_x_n;
            r_y        <= w_y_n;
            r_vx       <= w_vx_n;
            r_vy       <= w_vy_n;
            r_dx       <= w_dx_n;
            r_dy       <= w_dy_n;
            r_fric_cnt <= w_fric_n;
            r_hold_cnt <= w_hold_n;
            r_moving   <= (w_state_n != IDLE);
            r_wall_hit <= w_wall_hit_n;
        end
    end

    assign bus.x        = r_x;
    assign bus.y        = r_y;
    assign bus.vx       = r_vx;
    assign bus.vy       = r_vy;
    assign bus.dx       = r_dx;
    assign bus.dy       = r_dy;
    assign bus.moving   = r_moving;
    assign bus.wall_hit = r_wall_hit;
endmodule

// File: tb/tb_ball_motion.sv
// Directed plus randomized check of ball_motion against an integer kinematics model.
module tb_ball_motion;
    logic clk = 1'b0;
    logic rst;
    ball_motion_if bus ();

    ball_motion #(
        .X_MIN(10'd32), .X_MAX(10'd607), .Y_MIN(10'd32), .Y_MAX(10'd447),
        .INIT_X(10'd160), .INIT_Y(10'd240), .V_MAX(10'd15),
        .FRICTION_DIV(8), .HOLD_FRAMES(4)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int npass  = 0;
    int nfail  = 0;
    int ntotal = 0;

    // Model state: mode 0 = at rest, 1 = rolling, 2 = rolling with collisions masked
    int mx, my, mvx, mvy, mdx, mdy, mfric, mhold, mmode;
    bit mhit;
    int x_save;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        mx = 160; my = 240; mvx = 0; mvy = 0; mdx = 1; mdy = 1;
        mfric = 0; mhold = 0; mmode = 0; mhit = 0;
    endtask

    task automatic model_step();
        int a, n;
        mhit = 0;
        if (bus.coll_valid && mmode != 2) begin
            a = int'($signed(bus.coll_vx)); if (a < 0) a = -a; mvx = (a > 15) ? 15 : a;
            a = int'($signed(bus.coll_vy)); if (a < 0) a = -a; mvy = (a > 15) ? 15 : a;
            mdx = ($signed(bus.coll_dx) < 0) ? -1 : 1;
            mdy = ($signed(bus.coll_dy) < 0) ? -1 : 1;
            mhold = 4; mfric = 0;
            mmode = (mvx == 0 && mvy == 0) ? 0 : 2;
        end else if (mmode == 0) begin
            if (bus.place_valid) begin
                mx = clampi(int'(bus.place_x), 32, 607);
                my = clampi(int'(bus.place_y), 32, 447);
            end else if (bus.shot_valid) begin
                mvx = clampi(int'(bus.shot_vx), 0, 15);
                mvy = clampi(int'(bus.shot_vy), 0, 15);
                mdx = ($signed(bus.shot_dx) < 0) ? -1 : 1;
                mdy = ($signed(bus.shot_dy) < 0) ? -1 : 1;
                mfric = 0;
                if (mvx != 0 || mvy != 0) mmode = 1;
            end
        end else if (bus.frame_tick) begin
            n = mx + mdx * mvx;
            if (n >= 607)     begin mx = 607; mdx = -1; mhit = 1; end
            else if (n <= 32) begin mx = 32;  mdx = 1;  mhit = 1; end
            else mx = n;
            n = my + mdy * mvy;
            if (n >= 447)     begin my = 447; mdy = -1; mhit = 1; end
            else if (n <= 32) begin my = 32;  mdy = 1;  mhit = 1; end
            else my = n;
            mfric++;
            if (mfric == 8) begin
                mfric = 0;
                if (mvx > 0) mvx--;
                if (mvy > 0) mvy--;
            end
            if (mmode == 2) begin
                mhold--;
                if (mhold == 0) mmode = 1;
            end
            if (mvx == 0 && mvy == 0) begin mmode = 0; mfric = 0; end
        end
    endtask

    task automatic check_model();
        chk("x", bus.x, 10'(mx));
        chk("y", bus.y, 10'(my));
        chk("vx", bus.vx, 10'(mvx));
        chk("vy", bus.vy, 10'(mvy));
        chk("dx", bus.dx, 10'(mdx));
        chk("dy", bus.dy, 10'(mdy));
        chk("moving", {9'b0, bus.moving}, 10'(mmode != 0));
        chk("wall_hit", {9'b0, bus.wall_hit}, 10'(mhit));
    endtask

    task automatic clear_in();
        bus.frame_tick = 0; bus.place_valid = 0; bus.shot_valid = 0; bus.coll_valid = 0;
        bus.place_x = '0; bus.place_y = '0; bus.shot_vx = '0; bus.shot_vy = '0;
        bus.shot_dx = '0; bus.shot_dy = '0; bus.coll_vx = '0; bus.coll_vy = '0;
        bus.coll_dx = '0; bus.coll_dy = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_model();
        clear_in();
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_model();

        // Shot along +x, 8 frames then run down to rest
        bus.shot_valid = 1; bus.shot_vx = 10'd5; bus.shot_vy = 10'd0;
        bus.shot_dx = 10'sd1; bus.shot_dy = 10'sd1;
        cycle();
        repeat (8) begin bus.frame_tick = 1; cycle(); end
        chk("shot_x_after8", bus.x, 10'd200);
        chk("shot_vx_after8", bus.vx, 10'd4);
        chk("shot_moving", {9'b0, bus.moving}, 10'd1);
        repeat (32) begin bus.frame_tick = 1; cycle(); end
        chk("stop_vx", bus.vx, 10'd0);
        chk("stop_moving", {9'b0, bus.moving}, 10'd0);
        chk("stop_x", bus.x, 10'd280);

        // Respot near the right cushion and bounce
        bus.place_valid = 1; bus.place_x = 10'd600; bus.place_y = 10'd240;
        cycle();
        bus.shot_valid = 1; bus.shot_vx = 10'd10; bus.shot_dx = 10'sd1; bus.shot_dy = 10'sd1;
        cycle();
        bus.frame_tick = 1; cycle();
        chk("bounce_x", bus.x, 10'd607);
        chk("bounce_dx", bus.dx, 10'h3FF);
        chk("bounce_hit", {9'b0, bus.wall_hit}, 10'd1);
        cycle();
        chk("bounce_hit_clear", {9'b0, bus.wall_hit}, 10'd0);
        bus.frame_tick = 1; cycle();
        chk("bounce_x_next", bus.x, 10'd597);

        // Collision load, then a sustained level must not reload
        bus.coll_valid = 1; bus.coll_vx = -10'sd7; bus.coll_dx = -10'sd1;
        bus.coll_vy = 10'sd3; bus.coll_dy = 10'sd1;
        cycle();
        chk("coll_vx", bus.vx, 10'd7);
        chk("coll_dx", bus.dx, 10'h3FF);
        chk("coll_vy", bus.vy, 10'd3);
        chk("coll_dy", bus.dy, 10'd1);
        repeat (3) begin
            bus.coll_valid = 1; bus.coll_vx = 10'sd2; bus.coll_dx = 10'sd1;
            bus.coll_vy = 10'sd9; bus.coll_dy = -10'sd1; bus.frame_tick = 1;
            cycle();
        end
        chk("hold_vx", bus.vx, 10'd7);
        chk("hold_dx", bus.dx, 10'h3FF);
        chk("hold_x", bus.x, 10'd576);

        // Shot and place while rolling are ignored
        bus.shot_valid = 1; bus.shot_vx = 10'd1; bus.shot_dx = 10'sd1;
        bus.place_valid = 1; bus.place_x = 10'd100; bus.place_y = 10'd100;
        cycle();
        chk("ignore_x", bus.x, 10'd576);
        chk("ignore_vx", bus.vx, 10'd7);
        bus.frame_tick = 1; cycle();
        x_save = int'(bus.x);

        // Saturating collision with a simultaneous frame tick
        bus.coll_valid = 1; bus.coll_vx = -10'sd40; bus.coll_vy = 10'h200;
        bus.coll_dx = 10'sd1; bus.coll_dy = -10'sd1; bus.frame_tick = 1;
        cycle();
        chk("sat_vx", bus.vx, 10'd15);
        chk("sat_vy", bus.vy, 10'd15);
        chk("coll_tick_x", bus.x, 10'(x_save));

        // Randomized traffic
        repeat (600) begin
            bus.frame_tick  = ($urandom_range(0, 3) != 0);
            bus.coll_valid  = ($urandom_range(0, 24) == 0);
            bus.place_valid = ($urandom_range(0, 15) == 0);
            bus.shot_valid  = ($urandom_range(0, 5) == 0);
            bus.place_x = 10'($urandom);
            bus.place_y = 10'($urandom);
            bus.shot_vx = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 16));
            bus.shot_vy = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 16));
            bus.shot_dx = 10'($urandom);
            bus.shot_dy = 10'($urandom);
            bus.coll_vx = ($urandom_range(0, 1) == 0) ? 10'($urandom) : 10'($urandom_range(0, 32) - 16);
            bus.coll_vy = ($urandom_range(0, 1) == 0) ? 10'($urandom) : 10'($urandom_range(0, 32) - 16);
            bus.coll_dx = 10'($urandom);
            bus.coll_dy = 10'($urandom);
            cycle();
        end

        // Reset asserted mid-cycle while rolling
        bus.shot_valid = 1; bus.shot_vx = 10'd6; bus.shot_vy = 10'd4;
        bus.coll_valid = 1; bus.coll_vx = 10'sd5; bus.coll_vy = 10'sd2;
        bus.coll_dx = -10'sd1; bus.coll_dy = -10'sd1;
        cycle();
        bus.frame_tick = 1; cycle();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_x", bus.x, 10'd160);
        chk("rst_y", bus.y, 10'd240);
        chk("rst_vx", bus.vx, 10'd0);
        chk("rst_vy", bus.vy, 10'd0);
        chk("rst_dx", bus.dx, 10'd1);
        chk("rst_dy", bus.dy, 10'd1);
        chk("rst_moving", {9'b0, bus.moving}, 10'd0);
        chk("rst_wall_hit", {9'b0, bus.wall_hit}, 10'd0);
        model_reset();
        bus.shot_valid = 1; bus.shot_vx = 10'd9; bus.frame_tick = 1;
        @(posedge clk);
        @(negedge clk);
        clear_in();
        rst = 1'b0;
        #1;
        check_model();
        repeat (4) begin bus.frame_tick = 1; cycle(); end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
